// File: rtl/opcode_issuer.sv
// Opcode front-end: hands opcodes to the compiler with a Start pulse, then
// queues the instruction words it strobes back and serves them to the CPU fetch stage.
module opcode_issuer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [7:0]  OpIn,
   input  logic        OpValid,
   output logic        OpAccept,
   output logic [7:0]  Opcode,
   output logic        Start,
   input  logic        Ready,
   input  logic        GiveIns,
   input  logic [31:0] CPUIns,
   output logic [31:0] InsOut,
   output logic        InsValid,
   input  logic        InsTake,
   output logic        Busy,
   output logic        Timeout,
   output logic        Overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t        state, state_next;
   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] free_slots;
   logic [TW-1:0] timer;
   logic          saw_low;
   logic          full, capture, push, pop;
   logic          wait_done, wait_expired;

   assign InsValid     = (count != '0);
   assign Busy         = (state != IDLE);
   assign full         = (count == CW'(DEPTH));
   assign free_slots   = CW'(DEPTH) - count;
   assign pop          = InsValid & InsTake;
   assign capture      = GiveIns & ((state == START) || (state == WAIT));
   assign push         = capture & (~full | pop);
   assign wait_done    = Ready & saw_low;
   assign wait_expired = (timer == TW'(TIMEOUT - 1));

   // Gated by Rst so nothing is accepted while the FIFO is held in reset.
   assign OpAccept = ~Rst & (state == IDLE) & OpValid & Ready & (free_slots >= CW'(3));

   // NOTE: next-state is defaulted to the current state first, so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (OpAccept) state_next = START;
         START:   state_next = WAIT;
         WAIT:    if (wait_done || wait_expired) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state   <= IDLE;
         Opcode  <= '0;
         Start   <= 1'b0;
         timer   <= '0;
         saw_low <= 1'b0;
         Timeout <= 1'b0;
      end else begin
         state <= state_next;
         Start <= (state_next == START);
         if (OpAccept) Opcode <= OpIn;
         if (state == START) begin
            timer   <= '0;
            saw_low <= 1'b0;
         end else if (state == WAIT) begin
            timer <= timer + TW'(1);
            if (!Ready) saw_low <= 1'b1;
            // A regular completion in the final allowed cycle is not a timeout.
            if (!wait_done && wait_expired) Timeout <= 1'b1;
         end
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         InsOut   <= '0;
         Overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (capture && full && !pop) Overflow <= 1'b1;
         // InsOut is a head register: it moves only on a pop or a push into an empty queue.
         if (pop) begin
            if (count > CW'(1))  InsOut <= mem[rd_ptr + PW'(1)];
            else if (push)       InsOut <= CPUIns;
         end else if (push && (count == '0)) begin
            InsOut <= CPUIns;
         end
      end
   end

   // NOTE: the storage array has no reset; occupancy and the head register define what is valid.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= CPUIns;
   end

endmodule
